// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front end: window-fetch FSM states,
// default frame geometry and a helper for last-anchor positions.
package cnn_pkg;

  // Window fetcher control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Default geometry: 28x28 binary image, 3x3 windows, unit stride
  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_K      = 3;
  localparam int DEF_STRIDE = 1;
  localparam int DEF_DW     = 1;

  // Largest anchor coordinate reachable from 0 in steps of `stride`
  // without the window running past `extent`.
  function automatic int last_anchor(input int extent, input int k, input int stride);
    return ((extent - k) / stride) * stride;
  endfunction

endpackage

// File: rtl/ram.sv
// Simple dual-port frame store: one write port, one read port with a
// registered (1-cycle latency) read. Maps onto block RAM.
module ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; contents are never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/conv_window_fetch.sv
// Sliding-window pixel fetcher. Stores one raster frame and streams every
// KxK window (anchors stepped by STRIDE) as serial taps with valid/ready.
// Windows are fetched as soon as their last pixel has landed, so output
// overlaps reception. All addresses are formed incrementally (no multiply).
module conv_window_fetch
  import cnn_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int STRIDE = DEF_STRIDE,
  parameter int DW     = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          pix_vld,
  input  logic [DW-1:0] pix_data,
  output logic          in_rdy,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_pix,
  output logic          out_first,
  output logic          out_last,
  output logic          frame_done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N + 1);
  localparam int TW = $clog2(K + 1);

  // Geometry constants, all folded at elaboration time
  localparam logic [AW-1:0] N_A         = AW'(N);
  localparam logic [AW-1:0] IMG_W_A     = AW'(IMG_W);
  localparam logic [AW-1:0] COL_STEP    = AW'(STRIDE);
  localparam logic [AW-1:0] ROW_STEP    = AW'(STRIDE * IMG_W);
  localparam logic [AW-1:0] LAST_OFF    = AW'((K - 1) * IMG_W + K - 1);
  localparam logic [AW-1:0] C_LAST      = AW'(last_anchor(IMG_W, K, STRIDE));
  localparam logic [AW-1:0] R_LAST_BASE = AW'(last_anchor(IMG_H, K, STRIDE) * IMG_W);
  localparam logic [TW-1:0] K_LAST      = TW'(K - 1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] row_base_q, row_base_d;   // r * IMG_W of the current anchor
  logic [AW-1:0] col_q, col_d;             // anchor column c
  logic [AW-1:0] tap_base_q, tap_base_d;   // (r + i) * IMG_W of the current tap row
  logic [TW-1:0] tap_i_q, tap_i_d;
  logic [TW-1:0] tap_j_q, tap_j_d;
  logic          frame_done_q, frame_done_d;

  logic          wr_en;
  logic          ram_re;
  logic [AW-1:0] tap_addr;
  logic [AW-1:0] avail_addr;
  logic          win_avail;
  logic          tap_first;
  logic          tap_last;
  logic          anchor_final;
  logic [DW-1:0] ram_rdata;

  // Write side: accept pixels until the store is full; clr drops a
  // simultaneously presented pixel and rewinds the pointer.
  always_comb begin
    in_rdy   = (wr_ptr_q < N_A);
    wr_en    = pix_vld && in_rdy && !clr;
    wr_ptr_d = wr_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  // Window bookkeeping: last pixel of the window, current tap address
  // and the first/last tap and final anchor flags.
  always_comb begin
    avail_addr   = row_base_q + col_q + LAST_OFF;
    win_avail    = (wr_ptr_q > avail_addr);
    tap_addr     = tap_base_q + col_q + AW'(tap_j_q);
    tap_first    = (tap_i_q == '0) && (tap_j_q == '0);
    tap_last     = (tap_i_q == K_LAST) && (tap_j_q == K_LAST);
    anchor_final = (col_q == C_LAST) && (row_base_q == R_LAST_BASE);
  end

  // Next-state and counter update; clr overrides everything
  always_comb begin
    state_d      = state_q;
    row_base_d   = row_base_q;
    col_d        = col_q;
    tap_base_d   = tap_base_q;
    tap_i_d      = tap_i_q;
    tap_j_d      = tap_j_q;
    frame_done_d = 1'b0;
    ram_re       = 1'b0;

    if (clr) begin
      state_d    = ST_IDLE;
      row_base_d = '0;
      col_d      = '0;
      tap_base_d = '0;
      tap_i_d    = '0;
      tap_j_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_avail) begin
            state_d = ST_FETCH;
          end
        end

        ST_FETCH: begin
          ram_re  = 1'b1;
          state_d = ST_SEND;
        end

        ST_SEND: begin
          if (out_rdy) begin
            if (!tap_last) begin
              state_d = ST_FETCH;
              if (tap_j_q == K_LAST) begin
                tap_j_d    = '0;
                tap_i_d    = tap_i_q + 1'b1;
                tap_base_d = tap_base_q + IMG_W_A;
              end else begin
                tap_j_d = tap_j_q + 1'b1;
              end
            end else begin
              tap_i_d = '0;
              tap_j_d = '0;
              if (anchor_final) begin
                state_d      = ST_DONE;
                frame_done_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
                if (col_q == C_LAST) begin
                  // wrap to column 0 on the next anchor row
                  col_d      = '0;
                  row_base_d = row_base_q + ROW_STEP;
                  tap_base_d = row_base_q + ROW_STEP;
                end else begin
                  col_d      = col_q + COL_STEP;
                  tap_base_d = row_base_q;
                end
              end
            end
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state and frame_done pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Write pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Anchor and tap counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base_q <= '0;
      col_q      <= '0;
      tap_base_q <= '0;
      tap_i_q    <= '0;
      tap_j_q    <= '0;
    end else begin
      row_base_q <= row_base_d;
      col_q      <= col_d;
      tap_base_q <= tap_base_d;
      tap_i_q    <= tap_i_d;
      tap_j_q    <= tap_j_d;
    end
  end

  // Frame store; the read address only changes in FETCH, so the read data
  // (and therefore out_pix) holds steady while a tap is stalled in SEND.
  ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata(pix_data),
    .re   (ram_re),
    .raddr(tap_addr),
    .rdata(ram_rdata)
  );

  // Tap outputs are qualified by out_vld so they sit at zero otherwise
  always_comb begin
    out_vld    = (state_q == ST_SEND);
    out_pix    = out_vld ? ram_rdata : '0;
    out_first  = out_vld && tap_first;
    out_last   = out_vld && tap_last;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch: a 6x5/K3/S1/8-bit instance (A)
// and a 28x28/K3/S2/1-bit instance (B) sharing clock and reset.
`timescale 1ns/1ps
module tb_conv_window_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_clr, a_pix_vld, a_in_rdy, a_out_vld, a_out_rdy;
  logic       a_out_first, a_out_last, a_frame_done;
  logic [7:0] a_pix_data, a_out_pix;

  logic       b_clr, b_pix_vld, b_in_rdy, b_out_vld, b_out_rdy;
  logic       b_out_first, b_out_last, b_frame_done;
  logic [0:0] b_pix_data, b_out_pix;

  conv_window_fetch #(.IMG_W(6), .IMG_H(5), .K(3), .STRIDE(1), .DW(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .pix_vld(a_pix_vld), .pix_data(a_pix_data),
    .in_rdy(a_in_rdy), .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_pix(a_out_pix),
    .out_first(a_out_first), .out_last(a_out_last), .frame_done(a_frame_done)
  );

  conv_window_fetch #(.IMG_W(28), .IMG_H(28), .K(3), .STRIDE(2), .DW(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .pix_vld(b_pix_vld), .pix_data(b_pix_data),
    .in_rdy(b_in_rdy), .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_pix(b_out_pix),
    .out_first(b_out_first), .out_last(b_out_last), .frame_done(b_frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int tap_q[$];
  bit first_q[$];
  bit last_q[$];
  int n_fd, fd_cyc, last_acc_cyc, stab_bad, timed_out;
  int n_win, n_taps;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected tap k of the 6x5 frame when pixel i carries value i:
  // 4 anchor columns per row, 9 taps per window.
  function automatic int exp_a(input int k);
    int w = k / 9;
    int t = k % 9;
    return ((w / 4) + (t / 3)) * 6 + (w % 4) + (t % 3);
  endfunction

  // 1-bit test pattern for the 28x28 frame
  function automatic bit patb(input int a);
    return ((a ^ (a >> 2) ^ (a >> 5)) & 1) == 1;
  endfunction

  // Expected 9-bit window w of the 28x28 stride-2 frame, tap t in bit t
  function automatic int exp_b(input int w);
    int r = (w / 13) * 2;
    int c = (w % 13) * 2;
    int v = 0;
    for (int t = 0; t < 9; t++) begin
      if (patb((r + t / 3) * 28 + c + t % 3)) v = v | (1 << t);
    end
    return v;
  endfunction

  task automatic feed_a(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      if (i >= 30) chk("ovf in_rdy", int'(a_in_rdy), 0);
      a_pix_vld  = 1'b1;
      a_pix_data = 8'(i);
      tick();
    end
    a_pix_vld = 1'b0;
  endtask

  task automatic feed_b();
    for (int i = 0; i < 784; i++) begin
      b_pix_vld  = 1'b1;
      b_pix_data = patb(i);
      tick();
    end
    b_pix_vld = 1'b0;
  endtask

  // Consume A's taps with out_rdy high rdy_pct percent of the time; stop
  // after max_acc accepts (if nonzero) or shortly after frame_done.
  task automatic collect_a(input int rdy_pct, input int max_acc, input int budget);
    int acc = 0;
    int cyc = 0;
    bit held = 0;
    logic [7:0] hp = '0;
    logic hf = 1'b0, hl = 1'b0;
    tap_q.delete(); first_q.delete(); last_q.delete();
    n_fd = 0; fd_cyc = -100; last_acc_cyc = -100; stab_bad = 0; timed_out = 1;
    while (cyc < budget) begin
      if (a_frame_done) begin n_fd++; fd_cyc = cyc; end
      if (held && !(a_out_vld && a_out_pix === hp && a_out_first === hf && a_out_last === hl))
        stab_bad++;
      a_out_rdy = ($urandom_range(99) < rdy_pct);
      held = a_out_vld && !a_out_rdy;
      hp = a_out_pix; hf = a_out_first; hl = a_out_last;
      if (a_out_vld && a_out_rdy) begin
        tap_q.push_back(int'(a_out_pix));
        first_q.push_back(a_out_first);
        last_q.push_back(a_out_last);
        acc++;
        last_acc_cyc = cyc;
      end
      tick();
      cyc++;
      if ((max_acc > 0 && acc >= max_acc) || (n_fd > 0 && cyc > fd_cyc + 2)) begin
        timed_out = 0;
        break;
      end
    end
    a_out_rdy = 1'b0;
  endtask

  task automatic check_frame_a(input string tag);
    int flag_bad = 0;
    int nfirst = 0;
    chk({tag, " taps"}, tap_q.size(), 108);
    chk({tag, " timeout"}, timed_out, 0);
    chk({tag, " frame_done count"}, n_fd, 1);
    chk({tag, " frame_done latency"}, fd_cyc - last_acc_cyc, 1);
    chk({tag, " stall stability"}, stab_bad, 0);
    for (int k = 0; k < tap_q.size(); k++) begin
      chk($sformatf("%s tap%0d", tag, k), tap_q[k], exp_a(k));
      if (first_q[k] != (k % 9 == 0) || last_q[k] != (k % 9 == 8)) flag_bad++;
      if (first_q[k]) nfirst++;
      if (k % 9 == 8)
        $display("%s window %0d anchor (%0d,%0d) taps %0d..%0d", tag, k / 9,
                 (k / 9) / 4, (k / 9) % 4, tap_q[k - 8], tap_q[k]);
    end
    chk({tag, " first/last flags"}, flag_bad, 0);
    chk({tag, " windows"}, nfirst, 12);
  endtask

  task automatic collect_b(input int budget);
    int cyc = 0;
    int win = 0;
    int t = 0;
    n_win = 0; n_taps = 0; n_fd = 0; fd_cyc = -100; timed_out = 1;
    b_out_rdy = 1'b1;
    while (cyc < budget) begin
      if (b_frame_done) begin n_fd++; fd_cyc = cyc; end
      if (b_out_vld) begin
        if (t < 9 && b_out_pix[0]) win = win | (1 << t);
        t++;
        n_taps++;
        if (b_out_last) begin
          chk($sformatf("B win%0d", n_win), win, exp_b(n_win));
          $display("B window %0d anchor (%0d,%0d) bits %03h", n_win,
                   (n_win / 13) * 2, (n_win % 13) * 2, win);
          n_win++;
          t = 0;
          win = 0;
        end
      end
      tick();
      cyc++;
      if (n_fd > 0 && cyc > fd_cyc + 2) begin
        timed_out = 0;
        break;
      end
    end
    b_out_rdy = 1'b0;
  endtask

  int fw[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
  int lw[9] = '{15, 16, 17, 21, 22, 23, 27, 28, 29};
  int vld_cnt;

  initial begin
    rst_n = 1'b0;
    a_clr = 1'b0; a_pix_vld = 1'b0; a_pix_data = '0; a_out_rdy = 1'b0;
    b_clr = 1'b0; b_pix_vld = 1'b0; b_pix_data = '0; b_out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst out_vld", int'(a_out_vld), 0);
    chk("rst out_first", int'(a_out_first), 0);
    chk("rst out_last", int'(a_out_last), 0);
    chk("rst frame_done", int'(a_frame_done), 0);
    chk("rst out_pix", int'(a_out_pix), 0);
    chk("rst in_rdy", int'(a_in_rdy), 1);
    rst_n = 1'b1;
    tick();

    // full frame, always ready; a 31st pixel is offered after the store fills
    fork
      feed_a(0, 30);
      collect_a(100, 0, 1000);
    join
    check_frame_a("full");
    for (int k = 0; k < 9; k++) begin
      if (tap_q.size() == 108) begin
        chk($sformatf("first window tap%0d", k), tap_q[k], fw[k]);
        chk($sformatf("last window tap%0d", k), tap_q[99 + k], lw[k]);
      end
    end
    chk("done in_rdy", int'(a_in_rdy), 0);
    chk("done out_vld", int'(a_out_vld), 0);

    // clr from DONE
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr out_vld", int'(a_out_vld), 0);
    chk("clr in_rdy", int'(a_in_rdy), 1);

    // partial frame: pixels 0..13 never complete window (0,0)
    feed_a(0, 13);
    vld_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (a_out_vld) vld_cnt++;
    end
    chk("early out_vld cycles", vld_cnt, 0);
    a_pix_vld  = 1'b1;
    a_pix_data = 8'd14;
    tick();
    a_pix_vld = 1'b0;
    chk("E0 out_vld", int'(a_out_vld), 0);
    tick();
    chk("E1 out_vld", int'(a_out_vld), 0);
    tick();
    chk("E2 out_vld", int'(a_out_vld), 1);
    chk("E2 out_pix", int'(a_out_pix), 0);
    chk("E2 out_first", int'(a_out_first), 1);

    // rest of the frame under a 30% ready consumer
    fork
      feed_a(15, 29);
      collect_a(30, 0, 4000);
    join
    check_frame_a("rand");

    // clr after the 4th accepted tap, then refeed
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    feed_a(0, 29);
    collect_a(100, 4, 200);
    chk("pre-clr taps", tap_q.size(), 4);
    chk("pre-clr in_rdy", int'(a_in_rdy), 0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("post-clr out_vld", int'(a_out_vld), 0);
    chk("post-clr in_rdy", int'(a_in_rdy), 1);
    tick();
    chk("post-clr+1 out_vld", int'(a_out_vld), 0);
    fork
      feed_a(0, 29);
      collect_a(100, 0, 1000);
    join
    check_frame_a("refeed");

    // asynchronous reset while the last tap of window 0 is pending
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    feed_a(0, 29);
    collect_a(100, 8, 200);
    for (int i = 0; i < 5 && !a_out_vld; i++) tick();
    chk("pre-rst out_vld", int'(a_out_vld), 1);
    chk("pre-rst out_last", int'(a_out_last), 1);
    chk("pre-rst out_pix", int'(a_out_pix), 14);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst out_vld", int'(a_out_vld), 0);
    chk("async rst out_first", int'(a_out_first), 0);
    chk("async rst out_last", int'(a_out_last), 0);
    chk("async rst out_pix", int'(a_out_pix), 0);
    chk("async rst frame_done", int'(a_frame_done), 0);
    chk("async rst in_rdy", int'(a_in_rdy), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // 28x28, K=3, stride 2, 1-bit pixels
    fork
      feed_b();
      collect_b(8000);
    join
    chk("B windows", n_win, 169);
    chk("B taps", n_taps, 1521);
    chk("B frame_done count", n_fd, 1);
    chk("B timeout", timed_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
